// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU mode selector front end.
// Holds the FSM state encoding, default sizing and the debounce counter width helper.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      SELECT = 2'd0,
      LAUNCH = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int NUM_MODES_DEF       = 10;
   localparam int MODE_W_DEF          = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int DBC_CNT_W_DEF       = $clog2(DEBOUNCE_CYCLES_DEF + 1);

   // Counter must be able to hold the value DEBOUNCE_CYCLES itself.
   function automatic int dbc_cnt_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/alu_mode_selector_debouncer.sv
// Per-button front end: 2-flop synchronizer, restartable stability counter and
// a registered falling-edge detector that turns each debounced press into one pulse.
module button_debouncer
   import alu_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic level,
   output logic press
);

   localparam int CNT_W = dbc_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             r_sync_p0;
   logic             r_sync_p1;
   logic             r_level;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync_p0 <= 1'b1;
         r_sync_p1 <= 1'b1;
         r_level   <= 1'b1;
         r_press   <= 1'b0;
         r_cnt     <= '0;
      end else begin
         // synchronizer stage boundary
         r_sync_p0 <= btn_n;
         r_sync_p1 <= r_sync_p0;
         r_press   <= 1'b0;
         if (r_sync_p1 != r_level) begin
            if (r_cnt == CNT_MAX) begin
               r_level <= r_sync_p1;
               r_cnt   <= '0;
               r_press <= ~r_sync_p1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule

// File: rtl/alu_mode_selector.sv
// Mode browsing / launch controller for the ALU-with-modes block.
// Selector presses step the browsed mode; a start press latches it and fires a launch strobe.
module alu_mode_selector
   import alu_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int NUM_MODES       = NUM_MODES_DEF,
   parameter int MODE_W          = MODE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              selector_n,
   input  logic              start_n,
   output logic [MODE_W-1:0] mode,
   output logic [MODE_W-1:0] op_mode,
   output logic              start_pulse,
   output logic              locked,
   output logic              sel_event
);

   logic w_sel_level;
   logic w_sel_press;
   logic w_start_level;
   logic w_start_press;

   state_t            r_state;
   logic [MODE_W-1:0] r_mode;
   logic [MODE_W-1:0] r_op_mode;
   logic              r_start_pulse;
   logic              r_locked;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel_dbc (
      .clk   (clk),
      .rst   (rst),
      .btn_n (selector_n),
      .level (w_sel_level),
      .press (w_sel_press)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_dbc (
      .clk   (clk),
      .rst   (rst),
      .btn_n (start_n),
      .level (w_start_level),
      .press (w_start_press)
   );

   function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
      if (m == MODE_W'(NUM_MODES - 1)) return '0;
      else                             return m + 1'b1;
   endfunction

   // Start has priority over selector; presses during LAUNCH fall through unused.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= SELECT;
         r_mode        <= '0;
         r_op_mode     <= '0;
         r_start_pulse <= 1'b0;
         r_locked      <= 1'b0;
      end else begin
         case (r_state)
            SELECT: begin
               if (w_start_press) begin
                  r_state       <= LAUNCH;
                  r_start_pulse <= 1'b1;
               end else if (w_sel_press) begin
                  r_mode <= next_mode(r_mode);
               end
            end
            LAUNCH: begin
               r_op_mode     <= r_mode;
               r_start_pulse <= 1'b0;
               r_locked      <= 1'b1;
               r_state       <= LOCKED;
            end
            LOCKED: begin
               if (w_start_press) begin
                  r_state       <= LAUNCH;
                  r_start_pulse <= 1'b1;
                  r_locked      <= 1'b0;
               end else if (w_sel_press) begin
                  r_mode   <= next_mode(r_mode);
                  r_state  <= SELECT;
                  r_locked <= 1'b0;
               end
            end
            default: begin
               r_state       <= SELECT;
               r_start_pulse <= 1'b0;
               r_locked      <= 1'b0;
            end
         endcase
      end
   end

   assign mode        = r_mode;
   assign op_mode     = r_op_mode;
   assign start_pulse = r_start_pulse;
   assign locked      = r_locked;
   // Only selector presses the FSM actually acts on are made visible.
   assign sel_event   = w_sel_press & ~w_start_press & (r_state != LAUNCH);

endmodule

// File: tb/tb_alu_mode_selector.sv
// Directed, table-driven bench for alu_mode_selector (DEBOUNCE_CYCLES=4, NUM_MODES=10).
module tb_alu_mode_selector;

   localparam int MODE_W = 4;
   localparam int K_SEL = 0, K_START = 1, K_BOTH = 2, K_GLITCH = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              selector_n = 1'b1;
   logic              start_n = 1'b1;
   logic [MODE_W-1:0] mode;
   logic [MODE_W-1:0] op_mode;
   logic              start_pulse;
   logic              locked;
   logic              sel_event;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int kind;
      int mode;
      int op;
      int lk;
      int selc;
      int stc;
   } vec_t;

   vec_t tbl[33];

   alu_mode_selector #(
      .DEBOUNCE_CYCLES (4),
      .NUM_MODES       (10),
      .MODE_W          (MODE_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .selector_n  (selector_n),
      .start_n     (start_n),
      .mode        (mode),
      .op_mode     (op_mode),
      .start_pulse (start_pulse),
      .locked      (locked),
      .sel_event   (sel_event)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one press (or glitch) and watch 20 cycles; first-seen indices count ticks after the drive.
   task automatic do_press(input int kind, output int sel_cnt, output int st_cnt,
                           output int sel_first, output int st_first);
      int low_len;
      low_len   = (kind == K_GLITCH) ? 1 : 10;
      sel_cnt   = 0;
      st_cnt    = 0;
      sel_first = 0;
      st_first  = 0;
      if (kind != K_START) selector_n = 1'b0;
      if (kind == K_START || kind == K_BOTH) start_n = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == low_len) begin
            selector_n = 1'b1;
            start_n    = 1'b1;
         end
         if (sel_event) begin
            sel_cnt++;
            if (sel_first == 0) sel_first = i;
         end
         if (start_pulse) begin
            st_cnt++;
            if (st_first == 0) st_first = i;
         end
      end
   endtask

   initial begin
      int sc, stc, sf, stf, ev;

      //            kind      mode op lk selc stc
      tbl[0]  = '{K_SEL,    1, 0, 0, 1, 0};
      tbl[1]  = '{K_GLITCH, 1, 0, 0, 0, 0};
      tbl[2]  = '{K_SEL,    2, 0, 0, 1, 0};
      tbl[3]  = '{K_SEL,    3, 0, 0, 1, 0};
      tbl[4]  = '{K_GLITCH, 3, 0, 0, 0, 0};
      tbl[5]  = '{K_SEL,    4, 0, 0, 1, 0};
      tbl[6]  = '{K_SEL,    5, 0, 0, 1, 0};
      tbl[7]  = '{K_SEL,    6, 0, 0, 1, 0};
      tbl[8]  = '{K_SEL,    7, 0, 0, 1, 0};
      tbl[9]  = '{K_SEL,    8, 0, 0, 1, 0};
      tbl[10] = '{K_GLITCH, 8, 0, 0, 0, 0};
      tbl[11] = '{K_SEL,    9, 0, 0, 1, 0};
      tbl[12] = '{K_SEL,    0, 0, 0, 1, 0};
      tbl[13] = '{K_SEL,    1, 0, 0, 1, 0};
      tbl[14] = '{K_SEL,    2, 0, 0, 1, 0};
      tbl[15] = '{K_SEL,    3, 0, 0, 1, 0};
      tbl[16] = '{K_START,  3, 3, 1, 0, 1};
      tbl[17] = '{K_SEL,    4, 3, 0, 1, 0};
      tbl[18] = '{K_SEL,    5, 3, 0, 1, 0};
      tbl[19] = '{K_SEL,    6, 3, 0, 1, 0};
      tbl[20] = '{K_SEL,    7, 3, 0, 1, 0};
      tbl[21] = '{K_SEL,    8, 3, 0, 1, 0};
      tbl[22] = '{K_START,  8, 8, 1, 0, 1};
      tbl[23] = '{K_SEL,    9, 8, 0, 1, 0};
      tbl[24] = '{K_SEL,    0, 8, 0, 1, 0};
      tbl[25] = '{K_SEL,    1, 8, 0, 1, 0};
      tbl[26] = '{K_SEL,    2, 8, 0, 1, 0};
      tbl[27] = '{K_BOTH,   2, 2, 1, 0, 1};
      tbl[28] = '{K_SEL,    3, 2, 0, 1, 0};
      tbl[29] = '{K_SEL,    4, 2, 0, 1, 0};
      tbl[30] = '{K_SEL,    5, 2, 0, 1, 0};
      tbl[31] = '{K_START,  5, 5, 1, 0, 1};
      tbl[32] = '{K_START,  5, 5, 1, 0, 1};

      // Reset and idle
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_mode", int'(mode), 0);
      chk("rst_op_mode", int'(op_mode), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_start_pulse", int'(start_pulse), 0);
      chk("rst_sel_event", int'(sel_event), 0);
      ev = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (start_pulse || sel_event) ev++;
      end
      chk("idle_events", ev, 0);
      chk("idle_mode", int'(mode), 0);

      // Table-driven press sequence
      for (int i = 0; i < 33; i++) begin
         do_press(tbl[i].kind, sc, stc, sf, stf);
         chk($sformatf("v%0d_mode", i), int'(mode), tbl[i].mode);
         chk($sformatf("v%0d_op_mode", i), int'(op_mode), tbl[i].op);
         chk($sformatf("v%0d_locked", i), int'(locked), tbl[i].lk);
         chk($sformatf("v%0d_sel_events", i), sc, tbl[i].selc);
         chk($sformatf("v%0d_start_pulses", i), stc, tbl[i].stc);
         if (tbl[i].selc == 1) chk($sformatf("v%0d_sel_latency", i), sf, 7);
         if (tbl[i].stc == 1)  chk($sformatf("v%0d_start_latency", i), stf, 8);
      end

      // Mid-operation reset with the selector half-debounced
      selector_n = 1'b0;
      repeat (4) tick();
      rst        = 1'b1;
      selector_n = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_mode", int'(mode), 0);
      chk("mid_rst_op_mode", int'(op_mode), 0);
      chk("mid_rst_locked", int'(locked), 0);
      chk("mid_rst_start_pulse", int'(start_pulse), 0);
      chk("mid_rst_sel_event", int'(sel_event), 0);
      ev = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (start_pulse || sel_event) ev++;
      end
      chk("post_rst_events", ev, 0);
      chk("post_rst_mode", int'(mode), 0);

      // A fresh press after reset still works
      do_press(K_SEL, sc, stc, sf, stf);
      chk("post_rst_press_mode", int'(mode), 1);
      chk("post_rst_press_latency", sf, 7);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_mode_selector.md
Name: alu_mode_selector

Overview:
- Front-end controller driving the ALU-with-modes block from the two raw active-low board buttons, selector and start.
- Synchronizes and debounces both buttons and converts each press into a single-cycle event.
- Selector presses step a mode counter with wrap-around; a start press latches the browsed mode as the operating mode and fires a one-cycle start pulse toward the ALU datapath/display path.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced level changes (range 2..2^16).
NUM_MODES, 10, number of ALU operations; mode values 0..NUM_MODES-1.
MODE_W, 4, width of mode outputs; must satisfy 2^MODE_W >= NUM_MODES.

Ports:
clk  input  1  system clock.
rst  input  1  reset; one clock, synchronous, active-high.
selector_n  input  1  raw selector button, active-low (0 = pressed), asynchronous to clk.
start_n  input  1  raw start button, active-low, asynchronous to clk.
mode  output  MODE_W  currently browsed mode.
op_mode  output  MODE_W  mode latched at last launch; drives ALU opcode.
start_pulse  output  1  one-cycle launch strobe to the ALU.
locked  output  1  1 while in LOCKED state.
sel_event  output  1  one-cycle debounced selector press (debug/visibility).

Behaviour:
- Reset values, on any clk edge with rst=1, including mid-operation:
  - sync flops = 1 (released); debounced levels = 1; debounce counters = 0.
  - mode = 0, op_mode = 0, start_pulse = 0, locked = 0, sel_event = 0; FSM = SELECT.
- Synchronizer: 2-flop chain per button.
- Debounce, per button:
  - Counter increments each cycle the sync output differs from the debounced level.
  - Counter clears on any cycle they agree, so bounce restarts the count.
  - Debounced level takes the sync value when the counter reaches DEBOUNCE_CYCLES.
- Press event: one-cycle pulse on a debounced 1->0 transition; the release (0->1) produces no event.
- Latency: for a clean low level first sampled at edge E, the press event is high during cycle E+2+DEBOUNCE_CYCLES. One press yields exactly one event regardless of hold length.
- FSM states: SELECT, LAUNCH, LOCKED.
  - SELECT:
    - sel press -> mode <= (mode==NUM_MODES-1) ? 0 : mode+1.
    - start press -> LAUNCH.
  - LAUNCH (exactly 1 cycle):
    - op_mode <= mode; start_pulse = 1 this cycle only; next state LOCKED.
  - LOCKED:
    - locked = 1; op_mode held.
    - sel press -> mode increments (same wrap rule), state -> SELECT, locked drops next cycle.
    - start press -> LAUNCH again (relaunch with current mode).
- Simultaneous sel and start press in the same cycle: start wins, the selector press is discarded, mode unchanged.
- Presses arriving during the LAUNCH cycle are dropped. Debounce prevents back-to-back presses in practice.
- start_pulse is registered (Moore, decoded from the LAUNCH state). mode and op_mode are registered.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state_t enum {SELECT, LAUNCH, LOCKED};
  - default NUM_MODES and MODE_W constants;
  - localparam for the debounce counter width, $clog2(DEBOUNCE_CYCLES+1).
- Sub-module button_debouncer (params DEBOUNCE_CYCLES):
  - ports clk, rst, btn_n, level, press;
  - contains synchronizer, counter and edge detect;
  - instantiated twice.
- Top holds the FSM and mode registers only.

Test Plan (DEBOUNCE_CYCLES=4, NUM_MODES=10):
1. Reset then idle, buttons high -> mode=0, op_mode=0, locked=0, start_pulse never asserts over 50 cycles.
2. 7 clean selector presses (low 10 cycles, high 10 cycles each) -> one sel_event per press, 6 cycles after first low sample; final mode=7, op_mode=0.
3. 12 selector presses from reset -> mode sequence 1..9,0,1,2 (wrap at 9->0); 1-cycle glitches low (shorter than 4 stable) between presses -> no extra events.
4. Mode=3, start press -> start_pulse high exactly 1 cycle, op_mode=3, locked=1 from next cycle; then 5 selector presses -> first returns to SELECT, mode=8, op_mode stays 3; start again -> op_mode=8.
5. Selector and start driven low on the same cycle at mode=2 -> LAUNCH, op_mode=2, mode stays 2, no sel_event counted.
6. rst asserted 1 cycle while in LOCKED with mode=5 and a button half-debounced -> next cycle all outputs at reset values; released button produces no spurious event.
